// File: rtl/cu_sequencer_if.sv
// Control-unit sequencer bundle: datapath/memory status in, one-hot state and
// instruction bookkeeping out.
interface cu_sequencer_if #(
    parameter int STATES = 40,
    parameter int OP_W   = 5,
    parameter int CNT_W  = 16
);
    logic [OP_W-1:0]            opcode;
    logic [3:0]                 nzcv;
    logic                       mem_ready;
    logic                       halt;
    logic [STATES-1:0]          cpu_state;
    logic [$clog2(STATES)-1:0]  state_idx;
    logic                       branch_taken;
    logic                       instr_done;
    logic                       illegal_op;
    logic                       halted;
    logic [CNT_W-1:0]           instr_count;

    modport master (
        output opcode, nzcv, mem_ready, halt,
        input  cpu_state, state_idx, branch_taken, instr_done, illegal_op,
               halted, instr_count
    );

    modport slave (
        input  opcode, nzcv, mem_ready, halt,
        output cpu_state, state_idx, branch_taken, instr_done, illegal_op,
               halted, instr_count
    );
endinterface

// File: rtl/cu_sequencer.sv
// Microcode-style sequencer: fetch1-3, opcode decode to routine start states,
// memory-wait stalls, branch condition evaluation and retired-instruction count.
module cu_sequencer #(
    parameter int STATES = 40,
    parameter int OP_W   = 5,
    parameter int CNT_W  = 16
) (
    input logic          clk,
    input logic          rst,
    cu_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(STATES);

    typedef enum logic [IDX_W-1:0] {
        FETCH1 = IDX_W'(0),  FETCH2 = IDX_W'(1),  FETCH3 = IDX_W'(2),
        NOP    = IDX_W'(3),  MOV    = IDX_W'(4),  ALTMOV = IDX_W'(5),
        LDR    = IDX_W'(7),  ALTLDR = IDX_W'(9),  STR    = IDX_W'(13),
        ALTSTR = IDX_W'(17), CMP    = IDX_W'(21), B      = IDX_W'(22),
        BGT    = IDX_W'(23), BLT    = IDX_W'(24), BEQ    = IDX_W'(25),
        ADD    = IDX_W'(26), SUB    = IDX_W'(28), MUL    = IDX_W'(30),
        LSR    = IDX_W'(32), ANDOP  = IDX_W'(34), OROP   = IDX_W'(36),
        MVN    = IDX_W'(38)
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic             done_c;
    logic             illegal_c;
    logic             halted_c;
    logic             taken_c;
    logic             unused_c;

    function automatic logic is_last(input logic [IDX_W-1:0] s);
        case (32'(s))
            3, 4, 6, 8, 12, 16, 20, 21, 22, 23, 24, 25,
            27, 29, 31, 33, 35, 37, 39: is_last = 1'b1;
            default:                    is_last = 1'b0;
        endcase
    endfunction

    function automatic logic is_wait(input logic [IDX_W-1:0] s);
        case (32'(s))
            1, 8, 10, 12, 16, 20: is_wait = 1'b1;
            default:              is_wait = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH1;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (done_c)
                count <= count + CNT_W'(1);
        end
    end

    // Routine bodies simply step +1; only fetch1, fetch3 and illegal indices are special.
    always_comb begin
        state_nxt = state;
        done_c    = 1'b0;
        illegal_c = 1'b0;
        halted_c  = 1'b0;
        if (32'(state) >= 40) begin
            state_nxt = FETCH1;
        end else begin
            case (state)
                FETCH1: begin
                    if (bus.halt)
                        halted_c = 1'b1;
                    else
                        state_nxt = FETCH2;
                end
                FETCH3: begin
                    case (32'(bus.opcode))
                        0:  state_nxt = NOP;
                        1:  state_nxt = MOV;
                        2:  state_nxt = ALTMOV;
                        3:  state_nxt = LDR;
                        4:  state_nxt = ALTLDR;
                        5:  state_nxt = STR;
                        6:  state_nxt = ALTSTR;
                        7:  state_nxt = CMP;
                        8:  state_nxt = B;
                        9:  state_nxt = BGT;
                        10: state_nxt = BLT;
                        11: state_nxt = BEQ;
                        12: state_nxt = ADD;
                        13: state_nxt = SUB;
                        14: state_nxt = MUL;
                        15: state_nxt = LSR;
                        16: state_nxt = ANDOP;
                        17: state_nxt = OROP;
                        18: state_nxt = MVN;
                        default: begin
                            state_nxt = FETCH1;
                            illegal_c = 1'b1;
                        end
                    endcase
                end
                default: begin
                    if (is_wait(state) && !bus.mem_ready) begin
                        state_nxt = state;
                    end else if (is_last(state)) begin
                        state_nxt = FETCH1;
                        done_c    = 1'b1;
                    end else begin
                        state_nxt = state_t'(state + IDX_W'(1));
                    end
                end
            endcase
        end
    end

    // Flags are {N,Z,C,V}; the carry flag plays no part in any branch condition.
    always_comb begin
        taken_c = 1'b0;
        case (state)
            B:       taken_c = 1'b1;
            BGT:     taken_c = !bus.nzcv[2] && (bus.nzcv[3] == bus.nzcv[0]);
            BLT:     taken_c = bus.nzcv[3] != bus.nzcv[0];
            BEQ:     taken_c = bus.nzcv[2];
            default: taken_c = 1'b0;
        endcase
    end

    assign unused_c         = bus.nzcv[1];
    assign bus.state_idx    = state;
    assign bus.cpu_state    = STATES'(1) << state;
    assign bus.branch_taken = taken_c & ~rst;
    assign bus.instr_done   = done_c & ~rst;
    assign bus.illegal_op   = illegal_c & ~rst;
    assign bus.halted       = halted_c & ~rst;
    assign bus.instr_count  = count;
endmodule

// File: tb/tb_cu_sequencer.sv
// Directed scoreboard bench for cu_sequencer; a second instance with a 2-bit
// counter runs in lockstep to exercise counter wrap.
module tb_cu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    cu_sequencer_if #(.STATES(40), .OP_W(5), .CNT_W(16)) bus ();
    cu_sequencer_if #(.STATES(40), .OP_W(5), .CNT_W(2))  bus2 ();

    cu_sequencer #(.STATES(40), .OP_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    cu_sequencer #(.STATES(40), .OP_W(5), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    assign bus2.opcode    = bus.opcode;
    assign bus2.nzcv      = bus.nzcv;
    assign bus2.mem_ready = bus.mem_ready;
    assign bus2.halt      = bus.halt;

    always #5 clk = ~clk;

    typedef struct {
        int   st;
        logic bt;
        logic dn;
        logic il;
        logic hl;
        int   cnt;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   retired = 0;

    task automatic check1(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        check1("state_idx",    64'(bus.state_idx),    64'(e.st));
        check1("cpu_state",    64'(bus.cpu_state),    64'd1 << e.st);
        check1("branch_taken", 64'(bus.branch_taken), 64'(e.bt));
        check1("instr_done",   64'(bus.instr_done),   64'(e.dn));
        check1("illegal_op",   64'(bus.illegal_op),   64'(e.il));
        check1("halted",       64'(bus.halted),       64'(e.hl));
        check1("instr_count",  64'(bus.instr_count),  64'(e.cnt) & 64'hFFFF);
        check1("state_idx_w2", 64'(bus2.state_idx),   64'(e.st));
        check1("count_w2",     64'(bus2.instr_count), 64'(e.cnt) & 64'h3);
    endtask

    // One cycle: drive inputs just after the edge and queue what this cycle must show.
    task automatic applyStimulus(input logic r, input int op, input logic [3:0] f,
                                 input logic mr, input logic h, input int st,
                                 input logic bt, input logic dn, input logic il,
                                 input logic hl);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.opcode    = 5'(op);
        bus.nzcv      = f;
        bus.mem_ready = mr;
        bus.halt      = h;
        e.st  = st;
        e.bt  = bt;
        e.dn  = dn;
        e.il  = il;
        e.hl  = hl;
        e.cnt = retired;
        sb.push_back(e);
        if (r)
            retired = 0;
        else if (dn)
            retired++;
    endtask

    task automatic fetchOp(input int op, input logic il);
        applyStimulus(0, 0,  4'b0000, 1, 0, 0, 0, 0, 0,  0);
        applyStimulus(0, 0,  4'b0000, 1, 0, 1, 0, 0, 0,  0);
        applyStimulus(0, op, 4'b0000, 1, 0, 2, 0, 0, il, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0)
                checkOutput(sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bus.opcode    = '0;
        bus.nzcv      = '0;
        bus.mem_ready = 1'b0;
        bus.halt      = 1'b0;

        applyStimulus(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 4'b0000, 0, 1, 0, 0, 0, 0, 0);

        // add: 0,1,2,26,27 then back to fetch1
        fetchOp(12, 0);
        applyStimulus(0, 0, 4'b0000, 1, 0, 26, 0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 1, 0, 27, 0, 1, 0, 0);

        // ALTldr with a fetch2 stall, state 10 held four cycles, a stalled last state
        applyStimulus(0, 0, 4'b0000, 1, 0, 0,  0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 0, 0, 1,  0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 1, 0, 1,  0, 0, 0, 0);
        applyStimulus(0, 4, 4'b0000, 1, 0, 2,  0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 0, 0, 9,  0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 0, 0, 10, 0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 0, 1, 10, 0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 0, 0, 10, 0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 1, 0, 10, 0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 1, 0, 11, 0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 0, 0, 12, 0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 1, 0, 12, 0, 1, 0, 0);

        // branches
        fetchOp(9, 0);  applyStimulus(0, 0, 4'b0000, 1, 0, 23, 1, 1, 0, 0);
        fetchOp(9, 0);  applyStimulus(0, 0, 4'b0100, 1, 0, 23, 0, 1, 0, 0);
        fetchOp(9, 0);  applyStimulus(0, 0, 4'b1001, 1, 0, 23, 1, 1, 0, 0);
        fetchOp(10, 0); applyStimulus(0, 0, 4'b1000, 1, 0, 24, 1, 1, 0, 0);
        fetchOp(11, 0); applyStimulus(0, 0, 4'b0100, 1, 0, 25, 1, 1, 0, 0);
        fetchOp(11, 0); applyStimulus(0, 0, 4'b0010, 1, 0, 25, 0, 1, 0, 0);
        fetchOp(8, 0);  applyStimulus(0, 0, 4'b0000, 1, 0, 22, 1, 1, 0, 0);

        // illegal opcode returns straight to fetch1 without retiring
        fetchOp(25, 1);

        // halt raised on the last add cycle parks fetch1 after retirement
        fetchOp(12, 0);
        applyStimulus(0, 0, 4'b0000, 1, 0, 26, 0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 1, 1, 27, 0, 1, 0, 0);
        applyStimulus(0, 0, 4'b0000, 1, 1, 0,  0, 0, 0, 1);
        applyStimulus(0, 0, 4'b0000, 1, 1, 0,  0, 0, 0, 1);
        applyStimulus(0, 0, 4'b0000, 1, 0, 0,  0, 0, 0, 0);

        // str interrupted by reset in state 15, then halt honoured right after reset
        applyStimulus(0, 0, 4'b0000, 1, 0, 1,  0, 0, 0, 0);
        applyStimulus(0, 5, 4'b0000, 1, 0, 2,  0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 1, 0, 13, 0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 1, 0, 14, 0, 0, 0, 0);
        applyStimulus(1, 0, 4'b0000, 0, 0, 15, 0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 1, 1, 0,  0, 0, 0, 1);
        applyStimulus(0, 0, 4'b0000, 1, 0, 0,  0, 0, 0, 0);

        // four nops: the 2-bit counter wraps back to zero
        applyStimulus(0, 0, 4'b0000, 1, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 1, 0, 2, 0, 0, 0, 0);
        applyStimulus(0, 0, 4'b0000, 1, 0, 3, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            fetchOp(0, 0);
            applyStimulus(0, 0, 4'b0000, 1, 0, 3, 0, 1, 0, 0);
        end
        applyStimulus(0, 0, 4'b0000, 1, 1, 0, 0, 0, 0, 1);

        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cu_sequencer.md
CU_SEQUENCER -- requirements
Module: cu_sequencer

Interface
REQ-001 SHALL have parameter STATES, default 40, meaning the width of the one-hot state vector; values below 40 are illegal.
REQ-002 SHALL have parameter OP_W, default 5, meaning the opcode width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the retired-instruction counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port opcode, input, OP_W bits: the IR opcode field, sampled in fetch3.
REQ-007 SHALL have port nzcv, input, 4 bits: {N,Z,C,V} condition flags.
REQ-008 SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-009 SHALL have port halt, input, 1 bit: hold the sequencer at an instruction boundary.
REQ-010 SHALL have port cpu_state, output, STATES bits: one-hot current state that drives the control decode.
REQ-011 SHALL have port state_idx, output, $clog2(STATES) bits: binary index of the current state.
REQ-012 SHALL have port branch_taken, output, 1 bit: the branch condition is true in the current branch state.
REQ-013 SHALL have port instr_done, output, 1 bit: one-cycle pulse on the last cycle of a routine.
REQ-014 SHALL have port illegal_op, output, 1 bit: one-cycle pulse when fetch3 decodes an undefined opcode.
REQ-015 SHALL have port halted, output, 1 bit: the sequencer is parked in fetch1 because of halt.
REQ-016 SHALL have port instr_count, output, CNT_W bits: count of retired instructions.

Function
REQ-017 SHALL hold state in a registered binary index; cpu_state SHALL equal 1 << state_idx, with exactly one bit set at all times.
REQ-018 SHALL use the fixed state map: 0-2 fetch1-3; 3 nop; 4 mov; 5-6 ALTmov; 7-8 ldr; 9-12 ALTldr; 13-16 str; 17-20 ALTstr; 21 cmp; 22 b; 23 bgt; 24 blt; 25 beq; 26-27 add; 28-29 sub; 30-31 mul; 32-33 lsr; 34-35 and; 36-37 or; 38-39 mvn. States at index 40 and above are unused.
REQ-019 SHALL decode opcode values 0-18 in this order to routine start states: nop, mov, ALTmov, ldr, ALTldr, str, ALTstr, cmp, b, bgt, blt, beq, add, sub, mul, lsr, and, or, mvn (start states 3, 4, 5, 7, 9, 13, 17, 21, 22, 23, 24, 25, 26, 28, 30, 32, 34, 36, 38).
REQ-020 SHALL sequence fetch as fetch1 -> fetch2 -> fetch3 -> decoded start state.
REQ-021 SHALL, for an opcode of 19 or above, go from fetch3 to fetch1 and pulse illegal_op in the fetch3 cycle; instr_count SHALL NOT increment.
REQ-022 SHALL advance within a routine by +1 each cycle; the last state of each routine (3, 4, 6, 8, 12, 16, 20, 21, 22-25, 27, 29, 31, 33, 35, 37, 39) SHALL go to fetch1.
REQ-023 SHALL treat states {1, 8, 10, 12, 16, 20} as memory-wait states: the state is held while mem_ready=0 and advances in the cycle mem_ready=1.
REQ-024 SHALL drive branch_taken combinationally: state 22 always 1; state 23 when Z=0 and N==V; state 24 when N!=V; state 25 when Z=1; 0 in every other state. C is ignored.
REQ-025 SHALL assert instr_done combinationally in the cycle the sequencer leaves a routine's last state; in a memory-wait last state this is only the cycle mem_ready=1.
REQ-026 SHALL increment instr_count on the clock edge ending an instr_done cycle, wrapping modulo 2^CNT_W.
REQ-027 SHALL sample halt only in fetch1: halt=1 holds fetch1 and asserts halted (combinational); halt=0 proceeds to fetch2. halt asserted mid-instruction SHALL have no effect until the next fetch1.
REQ-028 SHALL send any illegal state_idx value (40 and above) to fetch1 on the next edge.

Reset
REQ-029 SHALL, when rst=1 at a rising edge, set state_idx=0, cpu_state=1 and instr_count=0, overriding every other input including mid-routine and mid-wait; branch_taken, instr_done and illegal_op SHALL be 0 during reset.
REQ-030 SHALL, on the first edge after rst falls, follow normal fetch1 rules, including halt.

Verification
REQ-031 The bench SHALL cover add: opcode=12 with mem_ready=1 -> states 0, 1, 2, 26, 27, 0; instr_done high in state 27; instr_count 0 -> 1.
REQ-032 The bench SHALL cover ALTldr wait: opcode=4 with mem_ready low for 3 cycles in state 10 -> state 10 held 4 cycles, then 11, 12, 0.
REQ-033 The bench SHALL cover branches: bgt with nzcv=4'b0000 -> branch_taken=1; bgt with 4'b0100 -> 0; blt with 4'b1000 -> 1; beq with 4'b0100 -> 1.
REQ-034 The bench SHALL cover an illegal opcode: opcode=25 -> illegal_op pulse in state 2, next state 0, instr_count unchanged.
REQ-035 The bench SHALL cover halt: halt=1 raised in state 27 -> instr completes, state 0 held with halted=1; halt=0 -> state 1 next cycle.
REQ-036 The bench SHALL cover reset and wrap: rst asserted in state 15 -> state 0 next edge, instr_count=0; with CNT_W=2, retiring 4 nops -> instr_count returns to 0.
